// File: rtl/mem_byte_sequencer_pkg.sv
// mem_pkg: shared size encodings, FSM states and byte-count helper for the byte sequencer
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_RESP} state_t;
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    return size == SZ_BYTE ? 3'd1 : size == SZ_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_byte_sequencer_if.sv
// mem_byte_sequencer_if: request/response handshake between datapath and byte sequencer
interface mem_byte_sequencer_if #(parameter int AW = 10, parameter int W = 8);
  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [1:0]     req_size;
  logic           req_signed;
  logic [AW-1:0]  req_addr;
  logic [4*W-1:0] req_wd;
  logic           rsp_valid;
  logic [4*W-1:0] rsp_rd;
  logic           rsp_err;
  modport master (output req_valid, req_we, req_size, req_signed, req_addr, req_wd,
                  input req_ready, rsp_valid, rsp_rd, rsp_err);
  modport slave (input req_valid, req_we, req_size, req_signed, req_addr, req_wd,
                 output req_ready, rsp_valid, rsp_rd, rsp_err);
endinterface

// File: rtl/mem_byte_sequencer_load_extend.sv
// load_extend: sign/zero-extends the captured little-endian load bytes to a full word
module load_extend
  import mem_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [4*WIDTH-1:0] i_buf,
  input  logic [1:0]         i_size,
  input  logic               i_signed,
  output logic [4*WIDTH-1:0] o_data
);
  logic w_bsign, w_hsign;
  assign w_bsign = i_signed & i_buf[WIDTH-1];
  assign w_hsign = i_signed & i_buf[2*WIDTH-1];
  assign o_data = i_size == SZ_BYTE ? {{3*WIDTH{w_bsign}}, i_buf[WIDTH-1:0]} :
                  i_size == SZ_HALF ? {{2*WIDTH{w_hsign}}, i_buf[2*WIDTH-1:0]} : i_buf;
endmodule

// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer: serialises byte/half/word loads and stores onto a byte-wide memory port
module mem_byte_sequencer
  import mem_pkg::*;
#(
  parameter  int DEPTH = 1024,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_byte_sequencer_if.slave  bus,
  output logic [AW-1:0]        o_mem_addr,
  output logic [WIDTH-1:0]     o_mem_wd,
  output logic                 o_mem_we,
  input  logic [WIDTH-1:0]     i_mem_rd
);
  state_t             r_state, w_next;
  logic               r_we, r_signed, r_err;
  logic [1:0]         r_size, r_k;
  logic [AW-1:0]      r_addr, r_last_addr, w_xaddr;
  logic [4*WIDTH-1:0] r_wd, r_buf, w_ext;
  logic               w_accept, w_req_err, w_last;
  logic [2:0]         w_req_n;
  logic [AW:0]        w_end;

  assign w_accept  = bus.req_valid & (r_state == ST_IDLE);
  assign w_req_n   = size_bytes(bus.req_size);
  // last byte address computed one bit wider so a request running past the top never wraps
  assign w_end     = {1'b0, bus.req_addr} + (AW+1)'(w_req_n - 3'd1);
  assign w_req_err = (bus.req_size == 2'b11) | ((bus.req_size == SZ_HALF) & bus.req_addr[0]) |
                     ((bus.req_size == SZ_WORD) & (|bus.req_addr[1:0])) | (w_end >= (AW+1)'(DEPTH));
  assign w_last    = {1'b0, r_k} == size_bytes(r_size) - 3'd1;
  assign w_xaddr   = r_addr + AW'(r_k);

  load_extend #(.WIDTH(WIDTH)) u_ext (
    .i_buf    (r_buf),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ext)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // next state: rejected requests skip XFER and respond immediately
  always_comb begin
    w_next = r_state == ST_IDLE ? (w_accept ? (w_req_err ? ST_RESP : ST_XFER) : ST_IDLE) :
             r_state == ST_XFER ? (w_last ? ST_RESP : ST_XFER) : ST_IDLE;
  end

  // request latch, byte counter, last memory address and load capture buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_signed    <= 1'b0;
      r_err       <= 1'b0;
      r_size      <= SZ_BYTE;
      r_k         <= 2'd0;
      r_addr      <= '0;
      r_last_addr <= '0;
      r_wd        <= '0;
      r_buf       <= '0;
    end else if (w_accept) begin
      r_we     <= bus.req_we;
      r_signed <= bus.req_signed;
      r_err    <= w_req_err;
      r_size   <= bus.req_size;
      r_k      <= 2'd0;
      r_addr   <= bus.req_addr;
      r_wd     <= bus.req_wd;
      r_buf    <= '0;
    end else if (r_state == ST_XFER) begin
      r_k         <= r_k + 2'd1;
      r_last_addr <= w_xaddr;
      if (!r_we) r_buf[r_k*WIDTH +: WIDTH] <= i_mem_rd;
    end
  end

  // outputs decoded from state so reset clears them without waiting for a clock
  always_comb begin
    bus.req_ready = r_state == ST_IDLE;
    bus.rsp_valid = r_state == ST_RESP;
    bus.rsp_err   = (r_state == ST_RESP) & r_err;
    bus.rsp_rd    = (r_state == ST_RESP) & !r_err & !r_we ? w_ext : '0;
    o_mem_we      = (r_state == ST_XFER) & r_we;
    o_mem_wd      = (r_state == ST_XFER) & r_we ? r_wd[r_k*WIDTH +: WIDTH] : '0;
    o_mem_addr    = r_state == ST_XFER ? w_xaddr : r_last_addr;
  end
endmodule
